// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-side types: RAM word and status, plus arbiter owner encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ARB_CORES = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    typedef struct packed {
        arb_src_t src;
        logic     core;
    } arb_owner_t;

    // Core chosen within one class: on a tie the core that did not go last, else the lone requester.
    function automatic logic rr_pick(input logic [ARB_CORES-1:0] req, input logic rr_last);
        if (req == 2'b11) begin
            return ~rr_last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/arb_priority_sel.sv
// Combinational requester selection: data class over instruction class, round-robin between cores.
module arb_priority_sel
    import cpu_types_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] req_d,
    input  logic       rr_last,
    output logic       any,
    output arb_owner_t pick
);

    always_comb begin
        any  = (|req_i) | (|req_d);
        pick = '{src: SRC_I, core: 1'b0};
        if (|req_d) begin
            pick = '{src: SRC_D, core: rr_pick(req_d, rr_last)};
        end else if (|req_i) begin
            pick = '{src: SRC_I, core: rr_pick(req_i, rr_last)};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Grants the single RAM port to one of two icaches / two dcaches and holds the grant
// until the owner drops its request, so multi-word bursts are never interleaved.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS = 2
)
(
    input  logic            CLK,
    input  logic            nRST,
    input  logic [CPUS-1:0] iREN,
    input  logic [31:0]     iaddr [CPUS],
    output logic [31:0]     iload [CPUS],
    output logic [CPUS-1:0] iwait,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  logic [31:0]     daddr [CPUS],
    input  logic [31:0]     dstore [CPUS],
    output logic [31:0]     dload [CPUS],
    output logic [CPUS-1:0] dwait,
    output logic            ramREN,
    output logic            ramWEN,
    output logic [31:0]     ramaddr,
    output logic [31:0]     ramstore,
    input  logic [31:0]     ramload,
    input  logic [1:0]      ramstate
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0] state;
    logic [0:0] next_state;
    arb_owner_t owner;
    arb_owner_t next_owner;
    logic       rr_last;
    logic       next_rr_last;

    logic            any;
    arb_owner_t      pick;
    logic [CPUS-1:0] req_d;
    logic            owner_req;
    logic            access;

    assign req_d  = dREN | dWEN;
    assign access = (ramstate_t'(ramstate) == ACCESS);

    arb_priority_sel u_sel (
        .req_i   (iREN),
        .req_d   (req_d),
        .rr_last (rr_last),
        .any     (any),
        .pick    (pick)
    );

    // Whether the current owner still holds its request this cycle.
    always_comb begin
        if (owner.src == SRC_D) begin
            owner_req = req_d[owner.core];
        end else begin
            owner_req = iREN[owner.core];
        end
    end

    // State, owner and round-robin registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            owner   <= '{src: SRC_I, core: 1'b0};
            rr_last <= 1'b1;
        end else begin
            state   <= next_state;
            owner   <= next_owner;
            rr_last <= next_rr_last;
        end
    end

    // Next-state logic and RAM/wait muxing; release always passes through IDLE before re-arbitrating.
    always_comb begin
        next_state   = state;
        next_owner   = owner;
        next_rr_last = rr_last;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = '1;
        dwait        = '1;

        case (state)
            IDLE: begin
                if (any) begin
                    next_owner   = pick;
                    next_rr_last = pick.core;
                    next_state   = OWN;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    next_state = IDLE;
                end
                if (owner.src == SRC_D) begin
                    ramaddr            = daddr[owner.core];
                    ramstore           = dstore[owner.core];
                    ramWEN             = dWEN[owner.core];
                    ramREN             = dREN[owner.core] & ~dWEN[owner.core];
                    dwait[owner.core]  = ~access;
                end else begin
                    ramaddr            = iaddr[owner.core];
                    ramREN             = iREN[owner.core];
                    iwait[owner.core]  = ~access;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Load data is broadcast; the wait lines tell each cache when it is valid.
    always_comb begin
        for (int i = 0; i < int'(CPUS); i++) begin
            iload[i] = ramload;
            dload[i] = ramload;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a request/grant reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN, iwait, dwait;
    logic [31:0] iaddr [2];
    logic [31:0] iload [2];
    logic [31:0] daddr [2];
    logic [31:0] dstore [2];
    logic [31:0] dload [2];
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int checks = 0;
    int passes = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        for (int k = 0; k < 2; k++) begin
            iaddr[k] = '0; daddr[k] = '0; dstore[k] = '0;
        end
        ramstate = 2'(FREE);
    endtask

    task automatic do_reset();
        idle_inputs();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        ramload = 32'h1234_5678;
        nRST = 1'b0;
        #2;
        checks++; if (ramREN !== 1'b0) $display("FAIL reset_ramREN got %b exp 0", ramREN); else passes++;
        checks++; if (ramWEN !== 1'b0) $display("FAIL reset_ramWEN got %b exp 0", ramWEN); else passes++;
        checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) $display("FAIL reset_ramaddr got %h/%h exp 0/0", ramaddr, ramstore); else passes++;
        checks++; if (iwait !== 2'b11 || dwait !== 2'b11) $display("FAIL reset_waits got %b/%b exp 11/11", iwait, dwait); else passes++;
        checks++; if (dload[1] !== 32'h1234_5678 || iload[0] !== 32'h1234_5678) $display("FAIL reset_load got %h/%h exp 12345678", dload[1], iload[0]); else passes++;
        nRST = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = 2'(BUSY);
        step();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) $display("FAIL single_c1 got ren=%b addr=%h exp 1/100", ramREN, ramaddr); else passes++;
        checks++; if (dwait !== 2'b11 || iwait !== 2'b11) $display("FAIL single_c1_wait got %b/%b exp 11/11", dwait, iwait); else passes++;
        step();
        checks++; if (ramREN !== 1'b1 || dwait[0] !== 1'b1) $display("FAIL single_c2 got ren=%b dwait0=%b exp 1/1", ramREN, dwait[0]); else passes++;
        step();
        ramstate = 2'(ACCESS); ramload = 32'hDEAD_BEEF;
        #1;
        checks++; if (dwait[0] !== 1'b0 || dload[0] !== 32'hDEAD_BEEF) $display("FAIL single_c3 got dwait0=%b dload0=%h exp 0/deadbeef", dwait[0], dload[0]); else passes++;
        checks++; if (dwait[1] !== 1'b1 || iwait !== 2'b11) $display("FAIL single_c3_other got %b/%b exp 1/11", dwait[1], iwait); else passes++;
        step();
        dREN[0] = 1'b0; ramstate = 2'(FREE);
        #1;
        checks++; if (ramREN !== 1'b0) $display("FAIL single_release got %b exp 0", ramREN); else passes++;
        step();
        checks++; if (dwait !== 2'b11 || ramaddr !== 32'h0) $display("FAIL single_idle got %b/%h exp 11/0", dwait, ramaddr); else passes++;
    endtask

    task automatic test_priority();
        do_reset();
        iREN[0] = 1'b1; iaddr[0] = 32'h400;
        dREN[1] = 1'b1; daddr[1] = 32'h500;
        ramstate = 2'(ACCESS);
        step();
        checks++; if (ramaddr !== 32'h500 || ramREN !== 1'b1) $display("FAIL prio_dfirst got addr=%h ren=%b exp 500/1", ramaddr, ramREN); else passes++;
        checks++; if (dwait !== 2'b01 || iwait !== 2'b11) $display("FAIL prio_waits got %b/%b exp 01/11", dwait, iwait); else passes++;
        step();
        dREN[1] = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || iwait[0] !== 1'b1) $display("FAIL prio_release got ren=%b iwait0=%b exp 0/1", ramREN, iwait[0]); else passes++;
        step();
        checks++; if (ramREN !== 1'b0 || iwait[0] !== 1'b1) $display("FAIL prio_gap got ren=%b iwait0=%b exp 0/1", ramREN, iwait[0]); else passes++;
        step();
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h400 || iwait !== 2'b10 || ramWEN !== 1'b0) $display("FAIL prio_igrant got ren=%b addr=%h iwait=%b wen=%b exp 1/400/10/0", ramREN, ramaddr, iwait, ramWEN); else passes++;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int c;
        do_reset();
        daddr[0] = 32'h1000; daddr[1] = 32'h2000;
        dREN = 2'b11; ramstate = 2'(ACCESS);
        for (int g = 0; g < 3; g++) begin
            c = g % 2;
            step();
            checks++; if (ramaddr !== daddr[c] || dwait[c] !== 1'b0 || dwait[1-c] !== 1'b1) $display("FAIL rr_grant%0d got addr=%h dwait=%b exp core %0d", g, ramaddr, dwait, c); else passes++;
            step();
            checks++; if (ramREN !== 1'b1 || ramaddr !== daddr[c]) $display("FAIL rr_beat2_%0d got ren=%b addr=%h", g, ramREN, ramaddr); else passes++;
            step();
            dREN[c] = 1'b0;
            #1;
            checks++; if (ramREN !== 1'b0) $display("FAIL rr_release%0d got %b exp 0", g, ramREN); else passes++;
            step();
            dREN[c] = 1'b1;
            #1;
            checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) $display("FAIL rr_idle%0d got ren=%b dwait=%b exp 0/11", g, ramREN, dwait); else passes++;
        end
        idle_inputs();
    endtask

    task automatic test_burst_hold();
        logic [31:0] addrs [4];
        addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h300; addrs[3] = 32'h304;
        do_reset();
        dREN[1] = 1'b1; daddr[1] = 32'h900;
        dWEN[0] = 1'b1; daddr[0] = addrs[0]; dstore[0] = 32'hA0;
        ramstate = 2'(ACCESS);
        step();
        for (int k = 0; k < 4; k++) begin
            dWEN[0] = (k < 2); dREN[0] = (k >= 2);
            daddr[0] = addrs[k]; dstore[0] = 32'hA0 + 32'(k);
            #1;
            checks++; if (ramaddr !== addrs[k] || ramWEN !== (k < 2) || ramREN !== (k >= 2) || dwait !== 2'b10) $display("FAIL burst_%0d got addr=%h wen=%b ren=%b dwait=%b exp %h", k, ramaddr, ramWEN, ramREN, dwait, addrs[k]); else passes++;
            if (k < 2) begin
                checks++; if (ramstore !== 32'hA0 + 32'(k)) $display("FAIL burst_store%0d got %h exp %h", k, ramstore, 32'hA0 + 32'(k)); else passes++;
            end
            step();
        end
        dREN[0] = 1'b0;
        #1;
        checks++; if (ramREN !== 1'b0 || dwait[1] !== 1'b1) $display("FAIL burst_release got ren=%b dwait1=%b exp 0/1", ramREN, dwait[1]); else passes++;
        step();
        step();
        checks++; if (ramaddr !== 32'h900 || dwait !== 2'b01) $display("FAIL burst_next got addr=%h dwait=%b exp 900/01", ramaddr, dwait); else passes++;
        idle_inputs();
    endtask

    task automatic test_conflict_reset();
        do_reset();
        dREN[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h700; ramstate = 2'(BUSY);
        step();
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || dwait[0] !== 1'b1) $display("FAIL conflict got wen=%b ren=%b dwait0=%b exp 1/0/1", ramWEN, ramREN, dwait[0]); else passes++;
        #1;
        nRST = 1'b0;
        #1;
        checks++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0) $display("FAIL midreset_strobe got wen=%b addr=%h exp 0/0", ramWEN, ramaddr); else passes++;
        checks++; if (dwait !== 2'b11 || iwait !== 2'b11) $display("FAIL midreset_waits got %b/%b exp 11/11", dwait, iwait); else passes++;
        nRST = 1'b1;
        #1;
        checks++; if (ramWEN !== 1'b0) $display("FAIL midreset_idle got wen=%b exp 0", ramWEN); else passes++;
        idle_inputs();
    endtask

    task automatic test_random();
        int          m_owner;
        bit          m_rr;
        bit          found;
        bit          req;
        int          cls, c;
        logic [1:0]  r;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic [1:0]  e_iw, e_dw;
        do_reset();
        m_owner = -1;
        m_rr = 1'b1;
        for (int n = 0; n < 400; n++) begin
            step();
            // Advance the model on the requests present at this edge.
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k >= 0; k--) begin
                    r = (k == 1) ? (dREN | dWEN) : iREN;
                    if (!found && r != 2'b00) begin
                        found = 1'b1;
                        if (r == 2'b11) c = m_rr ? 0 : 1;
                        else c = r[1] ? 1 : 0;
                        m_owner = k * 2 + c;
                        m_rr = (c == 1);
                    end
                end
            end else begin
                cls = m_owner / 2; c = m_owner % 2;
                req = (cls == 1) ? (dREN[c] | dWEN[c]) : iREN[c];
                if (!req) m_owner = -1;
            end
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 5) == 0) iREN[k] = ~iREN[k];
                if ($urandom_range(0, 5) == 0) dREN[k] = ~dREN[k];
                if ($urandom_range(0, 7) == 0) dWEN[k] = ~dWEN[k];
                iaddr[k] = $urandom; daddr[k] = $urandom; dstore[k] = $urandom;
            end
            ramstate = 2'($urandom_range(0, 3));
            ramload = $urandom;
            #1;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_iw = 2'b11; e_dw = 2'b11;
            if (m_owner >= 0) begin
                cls = m_owner / 2; c = m_owner % 2;
                if (cls == 1) begin
                    e_wen = dWEN[c]; e_ren = dREN[c] && !dWEN[c];
                    e_addr = daddr[c]; e_store = dstore[c];
                    e_dw[c] = (ramstate != 2'(ACCESS));
                end else begin
                    e_ren = iREN[c]; e_addr = iaddr[c];
                    e_iw[c] = (ramstate != 2'(ACCESS));
                end
            end
            checks++; if (ramREN !== e_ren) $display("FAIL rnd%0d_ramREN got %b exp %b", n, ramREN, e_ren); else passes++;
            checks++; if (ramWEN !== e_wen) $display("FAIL rnd%0d_ramWEN got %b exp %b", n, ramWEN, e_wen); else passes++;
            checks++; if (ramaddr !== e_addr) $display("FAIL rnd%0d_ramaddr got %h exp %h", n, ramaddr, e_addr); else passes++;
            checks++; if (ramstore !== e_store) $display("FAIL rnd%0d_ramstore got %h exp %h", n, ramstore, e_store); else passes++;
            checks++; if (iwait !== e_iw) $display("FAIL rnd%0d_iwait got %b exp %b", n, iwait, e_iw); else passes++;
            checks++; if (dwait !== e_dw) $display("FAIL rnd%0d_dwait got %b exp %b", n, dwait, e_dw); else passes++;
            checks++; if (iload[1] !== ramload || dload[0] !== ramload) $display("FAIL rnd%0d_load got %h/%h exp %h", n, iload[1], dload[0], ramload); else passes++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_round_robin();
        test_burst_hold();
        test_conflict_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Downstream bus stage between the per-core caches and the single RAM port. It accepts block requests from two icaches and two dcaches (two cores), grants the RAM to exactly one requester at a time, and holds that grant for the whole multi-word burst. It returns RAM load data and per-requester wait signals. Selection uses fixed data-over-instruction priority with round-robin between cores.

## Interface
Parameters:
- CPUS, 2, number of cores; the only supported value is 2.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  [CPUS]  icache read request, per core
- iaddr  in  [CPUS]x32  icache word address
- iload  out  [CPUS]x32  instruction data to icache
- iwait  out  [CPUS]  icache stall; 0 = access completes this cycle
- dREN  in  [CPUS]  dcache read request (block fill)
- dWEN  in  [CPUS]  dcache write request (writeback/flush)
- daddr  in  [CPUS]x32  dcache word address
- dstore  in  [CPUS]x32  dcache write data
- dload  out  [CPUS]x32  data to dcache
- dwait  out  [CPUS]  dcache stall; 0 = access completes this cycle
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

## Operation
- The FSM has two states. IDLE means no owner. OWN means owner {src, core} is registered.
- A requester is "requesting" as follows. A dcache requests when dREN|dWEN. An icache requests when iREN.
- IDLE, selection when any request is present:
  - Any dcache request beats any icache request.
  - Within a class, the core != rr_last wins on a tie. Otherwise the lone requester wins.
  - The selection registers owner, sets rr_last to the owner's core, and moves to OWN.
- IDLE with no request: stay in IDLE.
- OWN, RAM drive:
  - ramaddr and ramstore come from the owner.
  - For a dcache owner, ramWEN = dWEN. ramREN = dREN & ~dWEN, so WEN wins when both are asserted.
  - For an icache owner, ramREN = iREN and ramWEN = 0.
- OWN, owner wait: the owner's wait = (ramstate != ACCESS). BUSY, FREE and ERROR all stall.
- OWN, release:
  - When the owner's request drops, the FSM returns to IDLE that cycle.
  - ramREN/ramWEN are 0 in that cycle.
  - The FSM does not re-arbitrate in the same cycle.
  - The grant persists across address changes while the request stays high. This covers a writeback (2 words) followed by a fill (2 words).
- Non-owners: wait = 1 at all times.
- Load data: iload and dload for every port are driven with ramload, unconditionally.
- IDLE outputs: ramREN = ramWEN = 0, ramaddr = ramstore = 0, and all waits = 1.

## Timing
- Reset values:
  - FSM is in IDLE, rr_last = 1, owner = {SRC_I, 0}.
  - ramREN = ramWEN = 0, ramaddr = ramstore = 0.
  - iwait = dwait = all 1s, iload = dload = ramload.
- Arbitration latency is 1 cycle:
  - The request is sampled in IDLE at edge N.
  - The RAM is driven from cycle N+1.
- The wait-to-ACCESS path is combinational, so the completing word costs 0 extra cycles.
- Burst handoff: release takes 1 cycle and the next grant takes 1 more cycle. The minimum gap between two owners is 2 cycles.
- Simultaneous events:
  - A new request that arrives while the owner drops its request is only seen in the following IDLE cycle.
  - Requests from both cores in both classes in the same cycle resolve to dcache[core != rr_last].
- Reset mid-burst: the FSM returns to IDLE asynchronously and the RAM strobes drop immediately. The RAM is not required to complete the partial write.
- There is no starvation timeout. Fairness relies on the caches dropping their request after each block.

## Structure
- Defined in cpu_types_pkg:
  - word_t and ramstate_t (already present).
  - New typedef arb_src_t enum {SRC_I, SRC_D}.
  - New typedef arb_owner_t struct {arb_src_t src; logic core;}.
- Sub-module arb_priority_sel is combinational.
  - Inputs: req_i[2], req_d[2], rr_last.
  - Outputs: any, arb_owner_t pick.
- The mem_arbiter top holds the FSM, the owner/rr registers and the output muxing.

## Test plan
- Single read: dREN[0]=1, daddr[0]=0x100, RAM returns ACCESS at cycle 3 with ramload=0xDEADBEEF.
  - ramREN is high from cycle 1.
  - dwait[0]=0 and dload[0]=0xDEADBEEF in cycle 3.
  - dwait[1]=iwait=1 throughout.
- Priority: iREN[0]=1 and dREN[1]=1 in the same cycle.
  - dcache1 is granted first.
  - icache0 is granted 2 cycles after dcache1 drops dREN.
- Round-robin: dREN[0]=dREN[1]=1 held continuously, with each owner dropping after 2 ACCESS beats.
  - Grants alternate: core0 (rr_last=1 at reset), then core1, then core0.
- Burst hold: dcache0 runs dWEN for 0x200 and 0x204, then dREN for 0x300 and 0x304, with the request held high the whole time and dREN[1] pending.
  - Core1 is not granted until core0's request drops.
  - ramaddr follows 0x200, 0x204, 0x300, 0x304.
- Conflict and reset:
  - dREN[0]=dWEN[0]=1 gives ramWEN=1 and ramREN=0.
  - nRST pulsed low mid-burst gives ramWEN=0 within the same cycle, the FSM in IDLE, and all waits 1.
